// File: rtl/pattern_pwm_bank_pkg.sv
// pattern_pwm_bank_pkg: shared FSM state encoding and counter widths.
// Ports: none (package).
package pattern_pwm_bank_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PAT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
  localparam int DUR_W = 8;
  localparam int GAP_W = 16;
  localparam int REP_W = 8;
endpackage

// File: rtl/pattern_pwm_chan.sv
// pattern_pwm_chan: one pattern-PWM channel that replays a pattern MSB first.
// Ports: clk/rst (async active-high), start/stop strobes, shadow config
// (duty, dessert, num, pat, amp) sampled on an accepted start, pwm_out/busy/valid
// status, and lvl_nxt = the DAC level that this channel will present next cycle.
module pattern_pwm_chan
  import pattern_pwm_bank_pkg::*;
#(
  parameter int PAT_WIDTH = 16,
  parameter int DAC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DUR_W-1:0]     duty,
  input  logic [GAP_W-1:0]     dessert,
  input  logic [REP_W-1:0]     num,
  input  logic [PAT_WIDTH-1:0] pat,
  input  logic [DAC_WIDTH-1:0] amp,
  output logic                 pwm_out,
  output logic                 busy,
  output logic                 valid,
  output logic [DAC_WIDTH-1:0] lvl_nxt
);
  localparam int IDX_W = $clog2(PAT_WIDTH);
  localparam logic [IDX_W-1:0] MSB = IDX_W'(PAT_WIDTH - 1);
  state_t state, state_n;
  logic [DUR_W-1:0] cnt, cnt_n, dur, dur_n;
  logic [GAP_W-1:0] gcnt, gcnt_n, des, des_n;
  logic [REP_W-1:0] rem, rem_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [PAT_WIDTH-1:0] pat_r, pat_n;
  logic [DAC_WIDTH-1:0] amp_r, amp_n;
  logic inf, inf_n, load;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {cnt, dur, gcnt, des, rem, idx, pat_r, amp_r, inf} <= '0;
    end else begin
      state <= state_n;
      {cnt, dur, gcnt, des, rem, idx, pat_r, amp_r, inf} <=
        {cnt_n, dur_n, gcnt_n, des_n, rem_n, idx_n, pat_n, amp_n, inf_n};
    end
  always_comb begin
    state_n = state;
    {cnt_n, dur_n, gcnt_n, des_n, rem_n, idx_n, pat_n, amp_n, inf_n} =
      {cnt, dur, gcnt, des, rem, idx, pat_r, amp_r, inf};
    load = start && (state == IDLE || state == DONE);
    if (stop) state_n = IDLE;
    else if (load) begin
      state_n = PAT;
      cnt_n = '0;
      idx_n = MSB;
      dur_n = (duty == '0) ? DUR_W'(1) : duty;
      des_n = dessert;
      rem_n = num;
      inf_n = (num == '0);
      pat_n = pat;
      amp_n = amp;
    end else
      case (state)
        PAT:
          if (cnt != dur - DUR_W'(1)) cnt_n = cnt + DUR_W'(1);
          else begin
            cnt_n = '0;
            if (idx != '0) idx_n = idx - IDX_W'(1);
            else if (inf || rem > REP_W'(1)) begin
              // another repetition follows; infinite runs never touch rem
              rem_n = inf ? rem : rem - REP_W'(1);
              idx_n = MSB;
              gcnt_n = '0;
              state_n = (des == '0) ? PAT : GAP;
            end else state_n = DONE;
          end
        GAP:
          if (gcnt != des - GAP_W'(1)) gcnt_n = gcnt + GAP_W'(1);
          else begin
            idx_n = MSB;
            state_n = PAT;
          end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  assign busy = (state == PAT) || (state == GAP);
  assign valid = (state == DONE);
  assign pwm_out = (state == PAT) && pat_r[idx];
  // next-cycle level lets the top register the DAC in step with pwm_out
  assign lvl_nxt = (state_n == PAT && pat_n[idx_n]) ? amp_n : '0;
endmodule

// File: rtl/pattern_pwm_bank.sv
// pattern_pwm_bank: bank of independent pattern-PWM channels with shadow config.
// Ports: sys_clk/sys_rst (async active-high), cfg_* shadow write port,
// start/stop per-channel strobes, pwm_out/busy/valid per channel, and dac_data
// carrying cfg_amp of the last channel while its pwm_out is high.
module pattern_pwm_bank
  import pattern_pwm_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PAT_WIDTH = 16,
  parameter int DAC_WIDTH = 8,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [7:0]              cfg_duty,
  input  logic [15:0]             cfg_dessert,
  input  logic [7:0]              cfg_num,
  input  logic [PAT_WIDTH-1:0]    cfg_pat,
  input  logic [DAC_WIDTH-1:0]    cfg_amp,
  input  logic [NUM_CHANNELS-1:0] start,
  input  logic [NUM_CHANNELS-1:0] stop,
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic [NUM_CHANNELS-1:0] busy,
  output logic [NUM_CHANNELS-1:0] valid,
  output logic [DAC_WIDTH-1:0]    dac_data
);
  logic [DUR_W-1:0] sh_duty [NUM_CHANNELS];
  logic [GAP_W-1:0] sh_des [NUM_CHANNELS];
  logic [REP_W-1:0] sh_num [NUM_CHANNELS];
  logic [PAT_WIDTH-1:0] sh_pat [NUM_CHANNELS];
  logic [DAC_WIDTH-1:0] sh_amp [NUM_CHANNELS];
  logic [DAC_WIDTH-1:0] lvl [NUM_CHANNELS];
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst)
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        sh_duty[c] <= DUR_W'(1);
        sh_des[c] <= '0;
        sh_num[c] <= REP_W'(1);
        sh_pat[c] <= '0;
        sh_amp[c] <= '0;
      end
    else if (cfg_we && 32'(cfg_ch) < NUM_CHANNELS) begin
      sh_duty[cfg_ch] <= cfg_duty;
      sh_des[cfg_ch] <= cfg_dessert;
      sh_num[cfg_ch] <= cfg_num;
      sh_pat[cfg_ch] <= cfg_pat;
      sh_amp[cfg_ch] <= cfg_amp;
    end
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    pattern_pwm_chan #(.PAT_WIDTH(PAT_WIDTH), .DAC_WIDTH(DAC_WIDTH)) u_chan (
      .clk(sys_clk),
      .rst(sys_rst),
      .start(start[i]),
      .stop(stop[i]),
      .duty(sh_duty[i]),
      .dessert(sh_des[i]),
      .num(sh_num[i]),
      .pat(sh_pat[i]),
      .amp(sh_amp[i]),
      .pwm_out(pwm_out[i]),
      .busy(busy[i]),
      .valid(valid[i]),
      .lvl_nxt(lvl[i])
    );
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) dac_data <= '0;
    else dac_data <= lvl[NUM_CHANNELS-1];
endmodule
